// File: rtl/ped_req_ctrl.sv
// Pedestrian push-button front end: synchronize, debounce, latch a request until the FSM acks it.
// Optional post-ack cooldown lockout is compiled in when PED_REQ_COOLDOWN_EN is defined.
module ped_req_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int COOLDOWN_CYCLES = 50000000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_btn,
   input  logic       req_ack,
   output logic       ped_req,
   output logic       btn_db,
   output logic [7:0] press_cnt,
   output logic       busy
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic REL_LVL = BTN_ACTIVE_LOW;

`ifdef PED_REQ_COOLDOWN_EN
   localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

   logic [CD_W-1:0] cd_cnt, cd_nxt;
`else
   typedef enum logic [1:0] {IDLE, ARMED} state_t;
`endif

   state_t state, state_nxt;

   logic sync1, sync2, s;
   logic [DB_W-1:0] db_cnt;
   logic press_evt;
   logic [7:0] cnt_nxt;
   logic req_nxt, busy_nxt;

   // Synchronizer resets to the released pin level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= REL_LVL;
         sync2 <= REL_LVL;
      end else begin
         sync1 <= ped_btn;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ BTN_ACTIVE_LOW;

   // A new level must persist DEBOUNCE_CYCLES cycles; only the rising update emits a press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt    <= '0;
         btn_db    <= 1'b0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (s != btn_db) begin
            if (db_cnt == DB_LAST) begin
               btn_db    <= s;
               db_cnt    <= '0;
               press_evt <= s;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         press_cnt <= 8'd0;
         ped_req   <= 1'b0;
         busy      <= 1'b0;
`ifdef PED_REQ_COOLDOWN_EN
         cd_cnt    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         press_cnt <= cnt_nxt;
         ped_req   <= req_nxt;
         busy      <= busy_nxt;
`ifdef PED_REQ_COOLDOWN_EN
         cd_cnt    <= cd_nxt;
`endif
      end
   end

   // Ack takes priority over a coincident press in ARMED; outputs are decoded from the next state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = press_cnt;
`ifdef PED_REQ_COOLDOWN_EN
      cd_nxt    = cd_cnt;
`endif
      case (state)
         IDLE: begin
            if (press_evt) begin
               state_nxt = ARMED;
               if (press_cnt != 8'hFF) cnt_nxt = press_cnt + 8'd1;
            end
         end
         ARMED: begin
            if (req_ack) begin
`ifdef PED_REQ_COOLDOWN_EN
               state_nxt = COOLDOWN;
               cd_nxt    = CD_LAST;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef PED_REQ_COOLDOWN_EN
         COOLDOWN: begin
            if (cd_cnt == '0) state_nxt = IDLE;
            else cd_nxt = cd_cnt - CD_W'(1);
         end
`endif
         default: state_nxt = IDLE;
      endcase
      req_nxt  = (state_nxt == ARMED);
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_ped_req_ctrl.sv
// Directed bench for ped_req_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, active-low button.
// Expectations adapt to whether PED_REQ_COOLDOWN_EN is defined.
module tb_ped_req_ctrl;

`ifdef PED_REQ_COOLDOWN_EN
   localparam bit CD_EN = 1'b1;
`else
   localparam bit CD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       ped_btn;
   logic       req_ack;
   logic       ped_req;
   logic       btn_db;
   logic [7:0] press_cnt;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       btn;
      logic       ack;
      logic       exp_db;
      logic       exp_req;
      logic [7:0] exp_cnt;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[$];

   ped_req_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .COOLDOWN_CYCLES(8),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ped_btn  (ped_btn),
      .req_ack  (req_ack),
      .ped_req  (ped_req),
      .btn_db   (btn_db),
      .press_cnt(press_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic void add_vec(input bit b, input bit a, input bit db, input bit req,
                                   input int cnt, input bit bz);
      vec_t v;
      v.btn      = b;
      v.ack      = a;
      v.exp_db   = db;
      v.exp_req  = req;
      v.exp_cnt  = 8'(cnt);
      v.exp_busy = bz;
      vecs.push_back(v);
   endfunction

   // Inputs are set just after an edge and sampled 1 time unit after the next one.
   task automatic applyStimulus(input logic b, input logic a);
      ped_btn = b;
      req_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                              input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      int exp_cnt;

      for (int r = 0; r < 5; r++)
         for (int j = 0; j < 5; j++) add_vec(j >= 3, 0, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) add_vec(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) add_vec(0, 0, k >= 5, k >= 6, (k >= 6) ? 1 : 0, k >= 6);
      for (int k = 0; k < 7; k++) add_vec(1, 0, k < 5, 1, 1, 1);
      for (int k = 0; k < 8; k++) add_vec(0, 0, k >= 5, 1, 1, 1);
      for (int k = 0; k < 7; k++) add_vec(1, 0, k < 5, 1, 1, 1);
      // Press timed so its event reaches the FSM two cycles after the ack.
      for (int k = 0; k < 4; k++) add_vec(0, 0, 0, 1, 1, 1);
      add_vec(0, 1, 0, 0, 1, CD_EN);
      add_vec(0, 0, 1, 0, 1, CD_EN);
      add_vec(0, 0, 1, !CD_EN, CD_EN ? 1 : 2, 1);
      if (CD_EN) begin
         for (int r = 7; r < 14; r++) add_vec(1, 0, r < 12, 0, 1, r < 12);
         for (int r = 14; r < 22; r++) add_vec(0, 0, r >= 19, r >= 20, (r >= 20) ? 2 : 1, r >= 20);
         add_vec(0, 1, 1, 0, 2, 1);
         for (int r = 23; r < 30; r++) add_vec(1, 0, r < 28, 0, 2, 1);
         for (int r = 30; r < 32; r++) add_vec(1, 0, 0, 0, 2, 0);
      end else begin
         add_vec(0, 1, 1, 0, 2, 0);
         for (int r = 8; r < 15; r++) add_vec(1, 0, (r - 8) < 5, 0, 2, 0);
      end

      rst     = 1'b1;
      ped_btn = 1'b1;
      req_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req", 0, 8'(ped_req), 8'd0);
      checkOutput("reset_db", 0, 8'(btn_db), 8'd0);
      checkOutput("reset_cnt", 0, press_cnt, 8'd0);
      checkOutput("reset_busy", 0, 8'(busy), 8'd0);
      rst = 1'b0;
      applyStimulus(1, 0);
      applyStimulus(1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].btn, vecs[i].ack);
         checkOutput("vec_db", i, 8'(btn_db), 8'(vecs[i].exp_db));
         checkOutput("vec_req", i, 8'(ped_req), 8'(vecs[i].exp_req));
         checkOutput("vec_cnt", i, press_cnt, vecs[i].exp_cnt);
         checkOutput("vec_busy", i, 8'(busy), 8'(vecs[i].exp_busy));
      end

      // Collision: the press event reaches the FSM on the same edge as the ack.
      repeat (8) applyStimulus(0, 0);
      checkOutput("coll_arm_req", 0, 8'(ped_req), 8'd1);
      checkOutput("coll_arm_cnt", 0, press_cnt, 8'd3);
      repeat (8) applyStimulus(1, 0);
      repeat (6) applyStimulus(0, 0);
      applyStimulus(0, 1);
      checkOutput("coll_req", 0, 8'(ped_req), 8'd0);
      checkOutput("coll_cnt", 0, press_cnt, 8'd3);
      applyStimulus(0, 0);
      checkOutput("coll_req", 1, 8'(ped_req), 8'd0);
      checkOutput("coll_cnt", 1, press_cnt, 8'd3);
      checkOutput("coll_busy", 1, 8'(busy), 8'(CD_EN));
      repeat (16) applyStimulus(1, 0);

      exp_cnt = 3;
      for (int r = 0; r < 260; r++) begin
         repeat (8) applyStimulus(0, 0);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         checkOutput("sat_req", r, 8'(ped_req), 8'd1);
         checkOutput("sat_cnt", r, press_cnt, 8'(exp_cnt));
         repeat (8) applyStimulus(1, 0);
         applyStimulus(1, 1);
         repeat (9) applyStimulus(1, 0);
      end
      checkOutput("sat_final", 0, press_cnt, 8'd255);

      repeat (8) applyStimulus(0, 0);
      checkOutput("rst_pre_req", 0, 8'(ped_req), 8'd1);
      checkOutput("rst_pre_db", 0, 8'(btn_db), 8'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_req", 0, 8'(ped_req), 8'd0);
      checkOutput("async_busy", 0, 8'(busy), 8'd0);
      checkOutput("async_db", 0, 8'(btn_db), 8'd0);
      checkOutput("async_cnt", 0, press_cnt, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("held_rst_req", 0, 8'(ped_req), 8'd0);
      checkOutput("held_rst_cnt", 0, press_cnt, 8'd0);
      #2 rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
